// File: rtl/alu_pkg.sv
// Shared definitions for the alu_4bit slice: default datapath width and opcode map.
package alu_pkg;

   localparam int ALU_WIDTH = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational opcode decode and compute for alu_4bit; yields next Y, Cout and,
// when ALU_OVF_EN is defined, the signed-overflow flag V.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y,
   output logic             cout
`ifdef ALU_OVF_EN
   ,
   output logic             v
`endif
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum  = '0;
      y    = '0;
      cout = 1'b0;
      case (alu_op_e'(op))
         OP_ADD: begin
            sum  = {1'b0, a} + {1'b0, b};
            y    = sum[WIDTH-1:0];
            cout = sum[WIDTH];
         end
         // Cout is the true carry of A + ~B + 1, so it reads 1 when no borrow occurs.
         OP_SUB: begin
            sum  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            y    = sum[WIDTH-1:0];
            cout = sum[WIDTH];
         end
         OP_AND: y = a & b;
         OP_OR:  y = a | b;
         OP_XOR: y = a ^ b;
         OP_NOT: y = ~a;
         OP_SHL: begin
            y    = {a[WIDTH-2:0], 1'b0};
            cout = a[WIDTH-1];
         end
         OP_SHR: begin
            y    = {1'b0, a[WIDTH-1:1]};
            cout = a[0];
         end
         default: y = '0;
      endcase
   end

`ifdef ALU_OVF_EN
   always_comb begin
      v = 1'b0;
      case (alu_op_e'(op))
         OP_ADD:  v = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
         OP_SUB:  v = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
         default: v = 1'b0;
      endcase
   end
`endif

endmodule

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: one-cycle latency execute stage with carry and zero flags.
// Optional signed-overflow output V is built only when ALU_OVF_EN is defined.
module alu_4bit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       op,
   output logic             out_valid,
   output logic [WIDTH-1:0] Y,
   output logic             Cout,
   output logic             Zero
`ifdef ALU_OVF_EN
   ,
   output logic             V
`endif
);

   // Handshake: in_valid qualifies A/B/op at each rising edge; out_valid is high for
   // exactly the cycle after each accepted edge. No ready exists, so issue may occur
   // every cycle and results are never stalled.

   logic [WIDTH-1:0] y_n;
   logic             cout_n;
`ifdef ALU_OVF_EN
   logic             v_n;
`endif

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a    (A),
      .b    (B),
      .op   (op),
      .y    (y_n),
      .cout (cout_n)
`ifdef ALU_OVF_EN
      ,
      .v    (v_n)
`endif
   );

   // Zero is registered alongside Y because it must read 0 in reset while Y is also 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         Y         <= '0;
         Cout      <= 1'b0;
         Zero      <= 1'b0;
`ifdef ALU_OVF_EN
         V         <= 1'b0;
`endif
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            Y    <= y_n;
            Cout <= cout_n;
            Zero <= (y_n == '0);
`ifdef ALU_OVF_EN
            V    <= v_n;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: directed cases plus randomized ops against an
// arithmetic reference model. Build with +define+ALU_OVF_EN to cover V.
module tb_alu_4bit;

   localparam int W = 4;
   localparam int M = 1 << W;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic [2:0]   op = '0;
   logic         out_valid;
   logic [W-1:0] Y;
   logic         Cout;
   logic         Zero;
`ifdef ALU_OVF_EN
   logic         V;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // expected {v, zero, cout, y}
   logic [W+2:0] exp_q[$];
   logic [W+2:0] last_exp = '0;

   alu_4bit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .op        (op),
      .out_valid (out_valid),
      .Y         (Y),
      .Cout      (Cout),
      .Zero      (Zero)
`ifdef ALU_OVF_EN
      ,
      .V         (V)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model from the opcode table using integer arithmetic.
   function automatic logic [W+2:0] model(input int a, input int b, input int o);
      int y, c, v, sa, sb, sr;
      y = 0; c = 0; v = 0;
      sa = (a >= M/2) ? a - M : a;
      sb = (b >= M/2) ? b - M : b;
      case (o)
         0: begin y = (a + b) % M; c = (a + b >= M) ? 1 : 0; sr = sa + sb;
                  v = (sr < -M/2 || sr > M/2 - 1) ? 1 : 0; end
         1: begin y = (a - b + M) % M; c = (a >= b) ? 1 : 0; sr = sa - sb;
                  v = (sr < -M/2 || sr > M/2 - 1) ? 1 : 0; end
         2: y = a & b;
         3: y = a | b;
         4: y = a ^ b;
         5: y = M - 1 - a;
         6: begin y = (a * 2) % M; c = (a >= M/2) ? 1 : 0; end
         default: begin y = a / 2; c = a % 2; end
      endcase
      return {1'(v), 1'(y == 0), 1'(c), W'(y)};
   endfunction

   task automatic compare_outputs(input string tag);
      logic [W+2:0] e;
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_y"},     32'(Y),         32'(e[W-1:0]));
      check({tag, "_cout"},  32'(Cout),      32'(e[W]));
      check({tag, "_zero"},  32'(Zero),      32'(e[W+1]));
`ifdef ALU_OVF_EN
      check({tag, "_v"},     32'(V),         32'(e[W+2]));
`endif
      last_exp = e;
   endtask

   task automatic run_op(input int a, input int b, input int o, input string tag);
      @(negedge clk);
      A = W'(a); B = W'(b); op = 3'(o); in_valid = 1'b1;
      exp_q.push_back(model(a, b, o));
      @(posedge clk);
      #1;
      compare_outputs(tag);
   endtask

   task automatic idle(input string tag);
      @(negedge clk);
      in_valid = 1'b0;
      A = W'($urandom_range(0, M-1)); B = W'($urandom_range(0, M-1));
      @(posedge clk);
      #1;
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_hold_y"}, 32'(Y), 32'(last_exp[W-1:0]));
      check({tag, "_hold_c"}, 32'(Cout), 32'(last_exp[W]));
      check({tag, "_hold_z"}, 32'(Zero), 32'(last_exp[W+1]));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_y"},     32'(Y),         32'd0);
      check({tag, "_cout"},  32'(Cout),      32'd0);
      check({tag, "_zero"},  32'(Zero),      32'd0);
`ifdef ALU_OVF_EN
      check({tag, "_v"},     32'(V),         32'd0);
`endif
   endtask

   initial begin
      int exp_y[8];
      exp_y = '{7, 13, 0, 7, 7, 13, 4, 1};

      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Sweep A=2, B=5 over every opcode against literal expectations.
      for (int o = 0; o < 8; o++) begin
         run_op(2, 5, o, "sweep");
         check("sweep_lit_y", 32'(Y), 32'(exp_y[o]));
         check("sweep_lit_z", 32'(Zero), (o == 2) ? 32'd1 : 32'd0);
         if (o == 0 || o == 1 || o == 6 || o == 7)
            check("sweep_lit_c", 32'(Cout), 32'd0);
      end

      run_op(15, 1, 0, "add_wrap");
      check("add_wrap_lit", {28'd0, Zero, Cout, Y}, {28'd0, 1'b1, 1'b1, 4'h0});
      run_op(7, 1, 0, "add_ovf");
      check("add_ovf_lit", {28'd0, Cout, Y}, {28'd0, 1'b0, 4'h8});
`ifdef ALU_OVF_EN
      check("add_ovf_lit_v", 32'(V), 32'd1);
`endif
      run_op(5, 5, 1, "sub_eq");
      check("sub_eq_lit", {28'd0, Zero, Cout, Y}, {28'd0, 1'b1, 1'b1, 4'h0});
      run_op(9, 0, 6, "shl9");
      check("shl9_lit", {27'd0, Cout, Y}, {27'd0, 1'b1, 4'h2});
      run_op(9, 0, 7, "shr9");
      check("shr9_lit", {27'd0, Cout, Y}, {27'd0, 1'b1, 4'h4});

      // Single-cycle pulse then hold.
      run_op(2, 5, 0, "pulse");
      idle("pulse_off1");
      idle("pulse_off2");
      check("pulse_hold_lit", 32'(Y), 32'd7);

      // Asynchronous reset between edges discards the in-flight result.
      run_op(3, 4, 0, "pre_rst");
      @(negedge clk);
      A = 4'd6; B = 4'd6; op = 3'd0; in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      #1;
      check_all_zero("rst_held");
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      last_exp = '0;
      run_op(6, 3, 1, "post_rst");
      check("post_rst_lit", {28'd0, Cout, Y}, {28'd0, 1'b1, 4'h3});

      // Randomized traffic with occasional idle cycles.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0)
            idle("rand_idle");
         else
            run_op(int'($urandom_range(0, M-1)), int'($urandom_range(0, M-1)),
                   int'($urandom_range(0, 7)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
